misty_ks_pipe: RTL

- Parametrised MISTY1 key-schedule engine: accepts one 128-bit key and produces the 256-bit expanded key set (K ‖ K′), where K′i = FI(Ki, Ki+1) and K9 = K1.
- Replaces the fixed one-FI-per-cycle, 8-cycle, pulse-only key schedule.
- FI unrolling (and therefore latency) is configurable, and both sides use a valid/ready handshake.
- Sits between key loading and the round datapath (FO/FL key selection).

---
 rtl/misty_ks_pipe.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/misty_ks_pipe.sv
// MISTY1 key schedule (RFC 2994): K'i = FI(Ki, Ki+1), FI_PER_CYCLE FI units per cycle, valid/ready on both sides.
// Optional MISTY_KS_ZEROIZE_EN: the output handshake also clears the stored key material.

module misty_fi (
  input  logic [15:0] din,
  input  logic [15:0] key,
  output logic [15:0] dout
);
  localparam logic [6:0] S7_TAB [128] = '{
    7'h1b, 7'h32, 7'h33, 7'h5a, 7'h3b, 7'h10, 7'h17, 7'h54, 7'h5b, 7'h1a, 7'h72, 7'h73, 7'h6b, 7'h2c, 7'h66, 7'h49,
    7'h1f, 7'h24, 7'h13, 7'h6c, 7'h37, 7'h2e, 7'h3f, 7'h4a, 7'h5d, 7'h0f, 7'h40, 7'h56, 7'h25, 7'h51, 7'h1c, 7'h04,
    7'h0b, 7'h46, 7'h20, 7'h0d, 7'h7b, 7'h35, 7'h44, 7'h42, 7'h2b, 7'h1e, 7'h41, 7'h14, 7'h4b, 7'h79, 7'h15, 7'h6f,
    7'h0e, 7'h55, 7'h09, 7'h36, 7'h74, 7'h0c, 7'h67, 7'h53, 7'h28, 7'h0a, 7'h7e, 7'h38, 7'h02, 7'h07, 7'h60, 7'h29,
    7'h19, 7'h12, 7'h65, 7'h2f, 7'h30, 7'h39, 7'h08, 7'h68, 7'h5f, 7'h78, 7'h2a, 7'h4c, 7'h64, 7'h45, 7'h75, 7'h3d,
    7'h59, 7'h48, 7'h03, 7'h57, 7'h7c, 7'h4f, 7'h62, 7'h3c, 7'h1d, 7'h21, 7'h5e, 7'h27, 7'h6a, 7'h70, 7'h4d, 7'h3a,
    7'h01, 7'h6d, 7'h6e, 7'h63, 7'h18, 7'h77, 7'h23, 7'h05, 7'h26, 7'h76, 7'h00, 7'h31, 7'h2d, 7'h7a, 7'h7f, 7'h61,
    7'h50, 7'h22, 7'h11, 7'h06, 7'h47, 7'h16, 7'h52, 7'h4e, 7'h71, 7'h3e, 7'h69, 7'h43, 7'h34, 7'h5c, 7'h58, 7'h7d
  };

  localparam logic [8:0] S9_TAB [512] = '{
    9'h1c3, 9'h0cb, 9'h153, 9'h19f, 9'h1e3, 9'h0e9, 9'h0fb, 9'h035, 9'h181, 9'h0b9, 9'h117, 9'h1eb, 9'h133, 9'h009, 9'h02d, 9'h0d3,
    9'h0c7, 9'h14a, 9'h037, 9'h07e, 9'h0eb, 9'h164, 9'h193, 9'h1d8, 9'h0a3, 9'h11e, 9'h055, 9'h02c, 9'h01d, 9'h1a2, 9'h163, 9'h118,
    9'h14b, 9'h152, 9'h1d2, 9'h00f, 9'h02b, 9'h030, 9'h13a, 9'h0e5, 9'h111, 9'h138, 9'h18e, 9'h063, 9'h0e3, 9'h0c8, 9'h1f4, 9'h01b,
    9'h001, 9'h09d, 9'h0f8, 9'h1a0, 9'h16d, 9'h1f3, 9'h01c, 9'h146, 9'h07d, 9'h0d1, 9'h082, 9'h1ea, 9'h183, 9'h12d, 9'h0f4, 9'h19e,
    9'h1d3, 9'h0dd, 9'h1e2, 9'h128, 9'h1e0, 9'h0ec, 9'h059, 9'h091, 9'h011, 9'h12f, 9'h026, 9'h0dc, 9'h0b0, 9'h18c, 9'h10f, 9'h1f7,
    9'h0e7, 9'h16c, 9'h0b6, 9'h0f9, 9'h0d8, 9'h151, 9'h101, 9'h14c, 9'h103, 9'h0b8, 9'h154, 9'h12b, 9'h1ae, 9'h017, 9'h071, 9'h00c,
    9'h047, 9'h058, 9'h07f, 9'h1a4, 9'h134, 9'h129, 9'h084, 9'h15d, 9'h19d, 9'h1b2, 9'h1a3, 9'h048, 9'h07c, 9'h051, 9'h1ca, 9'h023,
    9'h13d, 9'h1a7, 9'h165, 9'h03b, 9'h042, 9'h0da, 9'h192, 9'h0ce, 9'h0c1, 9'h06b, 9'h09f, 9'h1f1, 9'h12c, 9'h184, 9'h0fa, 9'h196,
    9'h1e1, 9'h169, 9'h17d, 9'h031, 9'h180, 9'h10a, 9'h094, 9'h1da, 9'h186, 9'h13e, 9'h11c, 9'h060, 9'h175, 9'h1cf, 9'h067, 9'h119,
    9'h065, 9'h068, 9'h099, 9'h150, 9'h008, 9'h007, 9'h17c, 9'h0b7, 9'h024, 9'h019, 9'h0de, 9'h127, 9'h0db, 9'h0e4, 9'h1a9, 9'h052,
    9'h109, 9'h090, 9'h19c, 9'h1c1, 9'h028, 9'h1b3, 9'h135, 9'h16a, 9'h176, 9'h0df, 9'h1e5, 9'h188, 9'h0c5, 9'h16e, 9'h1de, 9'h1b1,
    9'h0c3, 9'h1df, 9'h036, 9'h0ee, 9'h1ee, 9'h0f0, 9'h093, 9'h049, 9'h09a, 9'h1b6, 9'h069, 9'h081, 9'h125, 9'h00b, 9'h05e, 9'h0b4,
    9'h149, 9'h1c7, 9'h174, 9'h03e, 9'h13b, 9'h1b7, 9'h08e, 9'h1c6, 9'h0ae, 9'h010, 9'h095, 9'h1ef, 9'h04e, 9'h0f2, 9'h1fd, 9'h085,
    9'h0fd, 9'h0f6, 9'h0a0, 9'h16f, 9'h083, 9'h08a, 9'h156, 9'h09b, 9'h13c, 9'h107, 9'h167, 9'h098, 9'h1d0, 9'h1e9, 9'h003, 9'h1fe,
    9'h0bd, 9'h122, 9'h089, 9'h0d2, 9'h18f, 9'h012, 9'h033, 9'h06a, 9'h142, 9'h0ed, 9'h170, 9'h11b, 9'h0e2, 9'h14f, 9'h158, 9'h131,
    9'h147, 9'h05d, 9'h113, 9'h1cd, 9'h079, 9'h161, 9'h1a5, 9'h179, 9'h09e, 9'h1b4, 9'h0cc, 9'h022, 9'h132, 9'h01a, 9'h0e8, 9'h004,
    9'h187, 9'h1ed, 9'h197, 9'h039, 9'h1bf, 9'h1d7, 9'h027, 9'h18b, 9'h0c6, 9'h09c, 9'h0d0, 9'h14e, 9'h06c, 9'h034, 9'h1f2, 9'h06e,
    9'h0ca, 9'h025, 9'h0ba, 9'h191, 9'h0fe, 9'h013, 9'h106, 9'h02f, 9'h1ad, 9'h172, 9'h1db, 9'h0c0, 9'h10b, 9'h1d6, 9'h0f5, 9'h1ec,
    9'h10d, 9'h076, 9'h114, 9'h1ab, 9'h075, 9'h10c, 9'h1e4, 9'h159, 9'h054, 9'h11f, 9'h04b, 9'h0c4, 9'h1be, 9'h0f7, 9'h029, 9'h0a4,
    9'h00e, 9'h1f0, 9'h077, 9'h04d, 9'h17a, 9'h086, 9'h08b, 9'h0b3, 9'h171, 9'h0bf, 9'h10e, 9'h104, 9'h097, 9'h15b, 9'h160, 9'h168,
    9'h0d7, 9'h0bb, 9'h066, 9'h1ce, 9'h0fc, 9'h092, 9'h1c5, 9'h06f, 9'h016, 9'h04a, 9'h0a1, 9'h139, 9'h0af, 9'h0f1, 9'h190, 9'h00a,
    9'h1aa, 9'h143, 9'h17b, 9'h056, 9'h18d, 9'h166, 9'h0d4, 9'h1fb, 9'h14d, 9'h194, 9'h19a, 9'h087, 9'h1f8, 9'h123, 9'h0a7, 9'h1b8,
    9'h141, 9'h03c, 9'h1f9, 9'h140, 9'h02a, 9'h155, 9'h11a, 9'h1a1, 9'h198, 9'h0d5, 9'h126, 9'h1af, 9'h061, 9'h12e, 9'h157, 9'h1dc,
    9'h072, 9'h18a, 9'h0aa, 9'h096, 9'h115, 9'h0ef, 9'h045, 9'h07b, 9'h08d, 9'h145, 9'h053, 9'h05f, 9'h178, 9'h0b2, 9'h02e, 9'h020,
    9'h1d5, 9'h03f, 9'h1c9, 9'h1e7, 9'h1ac, 9'h044, 9'h038, 9'h014, 9'h0b1, 9'h16b, 9'h0ab, 9'h0b5, 9'h05a, 9'h182, 9'h1c8, 9'h1d4,
    9'h018, 9'h177, 9'h064, 9'h0cf, 9'h06d, 9'h100, 9'h199, 9'h130, 9'h15a, 9'h005, 9'h120, 9'h1bb, 9'h1bd, 9'h0e0, 9'h04f, 9'h0d6,
    9'h13f, 9'h1c4, 9'h12a, 9'h015, 9'h006, 9'h0ff, 9'h19b, 9'h0a6, 9'h043, 9'h088, 9'h050, 9'h15f, 9'h1e8, 9'h121, 9'h073, 9'h17e,
    9'h0bc, 9'h0c2, 9'h0c9, 9'h173, 9'h189, 9'h1f5, 9'h074, 9'h1cc, 9'h1e6, 9'h1a8, 9'h195, 9'h01f, 9'h041, 9'h00d, 9'h1ba, 9'h032,
    9'h03d, 9'h1d1, 9'h080, 9'h0a8, 9'h057, 9'h1b9, 9'h162, 9'h148, 9'h0d9, 9'h105, 9'h062, 9'h07a, 9'h021, 9'h1ff, 9'h112, 9'h108,
    9'h1c0, 9'h0a9, 9'h11d, 9'h1b0, 9'h1a6, 9'h0cd, 9'h0f3, 9'h05c, 9'h102, 9'h05b, 9'h1d9, 9'h144, 9'h1f6, 9'h0ad, 9'h0a5, 9'h03a,
    9'h1cb, 9'h136, 9'h17f, 9'h046, 9'h0e1, 9'h01e, 9'h1dd, 9'h0e6, 9'h137, 9'h1fa, 9'h185, 9'h08c, 9'h08f, 9'h040, 9'h1b5, 9'h0be,
    9'h078, 9'h000, 9'h0ac, 9'h110, 9'h15e, 9'h124, 9'h002, 9'h1bc, 9'h0a2, 9'h0ea, 9'h070, 9'h1fc, 9'h116, 9'h15c, 9'h04c, 9'h1c2
  };

  logic [8:0] d9a, d9b, d9c;
  logic [6:0] d7a;

  assign d9a  = S9_TAB[din[15:7]] ^ {2'b00, din[6:0]};
  assign d7a  = S7_TAB[din[6:0]] ^ d9a[6:0] ^ key[15:9];
  assign d9b  = d9a ^ key[8:0];
  assign d9c  = S9_TAB[d9b] ^ {2'b00, d7a};
  assign dout = {d7a, d9c};
endmodule

module misty_ks_pipe #(
  parameter int unsigned FI_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] key_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [255:0] expand_keys_o
);
  localparam int unsigned LAT = 8 / FI_PER_CYCLE;
  localparam int unsigned CW  = (LAT > 1) ? $clog2(LAT) : 1;

  if (FI_PER_CYCLE != 1 && FI_PER_CYCLE != 2 && FI_PER_CYCLE != 4 && FI_PER_CYCLE != 8) begin : g_bad_cfg
    $error("misty_ks_pipe: FI_PER_CYCLE must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [7:0][15:0]   key_q;
  logic [7:0][15:0]   kp_q;
  logic               valid_q;
  logic               ready_q;

  logic [7:0][15:0]   src;
  logic [CW-1:0]      batch;
  logic [2:0]         wi    [FI_PER_CYCLE];
  logic [15:0]        fi_a  [FI_PER_CYCLE];
  logic [15:0]        fi_b  [FI_PER_CYCLE];
  logic [15:0]        fi_y  [FI_PER_CYCLE];

  // Batch 0 is fed straight from key_i so the load edge already produces useful FI results.
  // Word j (0-based) lives at index 7-j; the 3-bit j+1 wraps K8 onto K1.
  always_comb begin
    src   = (state == IDLE) ? key_i : key_q;
    batch = (state == IDLE) ? '0 : cnt;
    for (int unsigned l = 0; l < FI_PER_CYCLE; l++) begin
      wi[l]   = 3'(32'(batch) * FI_PER_CYCLE + l);
      fi_a[l] = src[3'd7 - wi[l]];
      fi_b[l] = src[3'd7 - (wi[l] + 3'd1)];
    end
  end

  for (genvar g = 0; g < FI_PER_CYCLE; g++) begin : g_fi
    misty_fi u_fi (
      .din  (fi_a[g]),
      .key  (fi_b[g]),
      .dout (fi_y[g])
    );
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state   <= IDLE;
      cnt     <= '0;
      key_q   <= '0;
      kp_q    <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i && ready_q) begin
            key_q <= key_i;
            for (int unsigned l = 0; l < FI_PER_CYCLE; l++) kp_q[3'd7 - wi[l]] <= fi_y[l];
            cnt     <= CW'(1);
            ready_q <= 1'b0;
            if (LAT > 1) begin
              state <= BUSY;
            end else begin
              state   <= DONE;
              valid_q <= 1'b1;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        BUSY: begin
          for (int unsigned l = 0; l < FI_PER_CYCLE; l++) kp_q[3'd7 - wi[l]] <= fi_y[l];
          cnt <= cnt + CW'(1);
          if (32'(cnt) == LAT - 1) begin
            state   <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (ready_i) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
`ifdef MISTY_KS_ZEROIZE_EN
            key_q   <= '0;
            kp_q    <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o       = ready_q;
  assign valid_o       = valid_q;
  assign expand_keys_o = {key_q, kp_q};
endmodule
